rx_deframer: RTL and testbench

- Consumes the boundary-detector outputs (BD_flag, BD_sgn) and the raw demodulated BPSK bit stream.
- Corrects phase ambiguity, packs bits MSB-first into bytes, parses a length-prefixed frame and emits payload bytes.
- At frame end it pulses disassert_BD back to the boundary detector so that detector re-arms for the next preamble.
- Sits directly downstream of the boundary detector, upstream of the byte sink / UART bridge.

---
 rtl/rx_pkg.sv | 17 +
 rtl/rx_crc8.sv | 39 +++
 rtl/rx_deframer.sv | 174 +++++++++++++++++
 tb/tb_rx_deframer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared constants for the rx deframer: FSM state encodings, CRC-8 parameters and the default byte width.
package rx_pkg;

  localparam int BYTE_W_DEF = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CRC     = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_ABORT   = 3'd5;
  localparam logic [2:0] ST_WAIT    = 3'd6;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

endpackage

// File: rtl/rx_crc8.sv
// Serial MSB-first CRC-8 over decoded bits; the updated value is visible the cycle after each enabled bit.
// Exists only when RX_DEFRAME_CRC_EN is defined; clr takes priority over en.
`ifdef RX_DEFRAME_CRC_EN
module rx_crc8
  import rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = crc_q[7] ^ bit_in;
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC8_INIT;
    end else if (en) begin
      crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC8_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule
`endif

// File: rtl/rx_deframer.sv
// Phase-corrects BPSK bits, packs MSB-first bytes, parses LEN-prefixed frames; RX_DEFRAME_CRC_EN adds a trailing CRC-8 check.
// Payload byte appears 1 cycle after its last bit; no backpressure, a bit is consumed on every bit_vld cycle.
module rx_deframer
  import rx_pkg::*;
#(
  parameter int BYTE_W  = BYTE_W_DEF,
  parameter int MAX_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              BPSK,
  input  logic              bit_vld,
  input  logic              PD_flag,
  input  logic              BD_flag,
  input  logic              BD_sgn,
  output logic [BYTE_W-1:0] data,
  output logic              data_vld,
  output logic              frame_done,
  output logic              frame_err,
  output logic              disassert_BD,
  output logic              busy
);

  localparam int BC_W  = $clog2(BYTE_W);
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam logic [BC_W-1:0]   BIT_LAST  = BC_W'(BYTE_W - 1);
  localparam logic [BYTE_W-1:0] MAX_LEN_B = BYTE_W'(MAX_LEN);
`ifdef RX_DEFRAME_CRC_EN
  localparam logic [2:0] ST_TAIL = ST_CRC;
`else
  localparam logic [2:0] ST_TAIL = ST_DONE;
`endif

  logic [2:0]        state_q, state_d;
  logic              sgn_q, sgn_d;
  logic [BYTE_W-1:0] sr_q, sr_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              data_vld_q, data_vld_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic              disassert_q, disassert_d;

  logic in_frame, shift_en, byte_end, dec_bit;

`ifdef RX_DEFRAME_CRC_EN
  logic [7:0] crc_val;

  rx_crc8 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_IDLE),
    .en     (shift_en && (state_q != ST_CRC)),
    .bit_in (dec_bit),
    .crc    (crc_val)
  );
`endif

  always_comb begin
    in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CRC);
    dec_bit  = BPSK ^ sgn_q;
    shift_en = in_frame && bit_vld;
    byte_end = shift_en && (bit_cnt_q == BIT_LAST);

    state_d      = state_q;
    sgn_d        = sgn_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    len_d        = len_q;
    data_d       = data_q;
    data_vld_d   = 1'b0;
    // Completion strobes trail their state by a cycle so they never share a cycle with the last data_vld.
    frame_done_d = (state_q == ST_DONE);
    frame_err_d  = (state_q == ST_ABORT);
    disassert_d  = (state_q == ST_DONE) || (state_q == ST_ABORT);

    if (shift_en) begin
      sr_d      = {sr_q[BYTE_W-2:0], dec_bit};
      bit_cnt_d = bit_cnt_q + BC_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (BD_flag && PD_flag) begin
          sgn_d      = BD_sgn;
          sr_d       = '0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          state_d    = ST_LEN;
        end
      end
      ST_LEN: begin
        if (byte_end) begin
          if ((sr_d == '0) || (sr_d > MAX_LEN_B)) begin
            state_d = ST_ABORT;
          end else begin
            len_d      = CNT_W'(sr_d);
            byte_cnt_d = '0;
            state_d    = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (byte_end) begin
          data_d     = sr_d;
          data_vld_d = 1'b1;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (byte_cnt_d == len_q) begin
            state_d = ST_TAIL;
          end
        end
      end
`ifdef RX_DEFRAME_CRC_EN
      ST_CRC: begin
        if (byte_end) begin
          state_d = (sr_d == crc_val) ? ST_DONE : ST_ABORT;
        end
      end
`endif
      ST_DONE:  state_d = ST_WAIT;
      ST_ABORT: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!BD_flag) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    // Losing the preamble overrides any in-frame transition, including the last-byte hand-off.
    if (in_frame && !PD_flag) begin
      state_d = ST_ABORT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sgn_q        <= 1'b0;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      len_q        <= '0;
      data_q       <= '0;
      data_vld_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      disassert_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sgn_q        <= sgn_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      len_q        <= len_d;
      data_q       <= data_d;
      data_vld_q   <= data_vld_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      disassert_q  <= disassert_d;
    end
  end

  assign data         = data_q;
  assign data_vld     = data_vld_q;
  assign frame_done   = frame_done_q;
  assign frame_err    = frame_err_q;
  assign disassert_BD = disassert_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_deframer.sv
// Directed bench for rx_deframer: good/inverted/gapped frames, bad lengths, PD drops, reset mid-frame, CRC under RX_DEFRAME_CRC_EN.
module tb_rx_deframer;

  localparam int BYTE_W  = 8;
  localparam int MAX_LEN = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              BPSK;
  logic              bit_vld;
  logic              PD_flag;
  logic              BD_flag;
  logic              BD_sgn;
  logic [BYTE_W-1:0] data;
  logic              data_vld;
  logic              frame_done;
  logic              frame_err;
  logic              disassert_BD;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_q[$];
  int         n_done;
  int         n_err;

  rx_deframer #(.BYTE_W(BYTE_W), .MAX_LEN(MAX_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .BPSK         (BPSK),
    .bit_vld      (bit_vld),
    .PD_flag      (PD_flag),
    .BD_flag      (BD_flag),
    .BD_sgn       (BD_sgn),
    .data         (data),
    .data_vld     (data_vld),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .disassert_BD (disassert_BD),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Record strobes mid-cycle and enforce pairing/exclusivity whenever any strobe is up.
  always @(negedge clk) begin
    if (data_vld) got_q.push_back(data);
    if (frame_done) n_done++;
    if (frame_err) n_err++;
    if (data_vld || frame_done || frame_err || disassert_BD) begin
      check("disassert_pairing", 32'(disassert_BD), 32'(frame_done || frame_err));
      check("strobe_excl", 32'((data_vld && (frame_done || frame_err)) || (frame_done && frame_err)), 32'd0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic v);
    BPSK    = b;
    bit_vld = v;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] v, input logic inv, input bit gaps);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i] ^ inv, 1'b1);
      if (gaps) begin
        g = 1'($urandom_range(0, 1));
        send_bit(g, 1'b0);
      end
    end
  endtask

  function automatic logic [7:0] crc8_of(input logic [7:0] b[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (b[k]) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[7] ^ b[k][i];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic clear_log();
    got_q.delete();
    n_done = 0;
    n_err  = 0;
  endtask

  // Start cycle carries a 1 that must not be captured; BD_sgn flips afterwards to prove it was latched.
  task automatic start_frame(input logic sgn);
    BD_flag = 1'b1;
    PD_flag = 1'b1;
    BD_sgn  = sgn;
    send_bit(1'b1, 1'b1);
    BD_sgn  = ~sgn;
  endtask

  task automatic send_frame(input logic [7:0] q[$], input logic inv, input bit gaps);
    foreach (q[k]) send_byte(q[k], inv, gaps);
`ifdef RX_DEFRAME_CRC_EN
    send_byte(crc8_of(q), inv, gaps);
`endif
  endtask

  task automatic end_frame(input string tag);
    int k;
    k = 0;
    bit_vld = 1'b0;
    while ((n_done + n_err) == 0 && k < 40) begin
      tick();
      k++;
    end
    check({tag, "_busy_in_wait"}, 32'(busy), 32'd1);
    BD_flag = 1'b0;
    PD_flag = 1'b0;
    tick();
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] exp[$], input int e_done, input int e_err);
    check({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp.size()));
    foreach (exp[k]) begin
      if (k < got_q.size()) check({tag, "_byte"}, 32'(got_q[k]), 32'(exp[k]));
    end
    check({tag, "_done"}, 32'(n_done), 32'(e_done));
    check({tag, "_err"}, 32'(n_err), 32'(e_err));
  endtask

  initial begin
    logic [7:0] fq[$];
    logic [7:0] eq[$];

    rst = 1'b1; BPSK = 1'b0; bit_vld = 1'b0; PD_flag = 1'b0; BD_flag = 1'b0; BD_sgn = 1'b0;
    repeat (3) tick();
    check("rst_data", 32'(data), 32'd0);
    check("rst_data_vld", 32'(data_vld), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_disassert", 32'(disassert_BD), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    clear_log();
    fq = '{8'h02, 8'hA5, 8'h3C};
    start_frame(1'b0);
    send_frame(fq, 1'b0, 1'b0);
    end_frame("good");
    eq = '{8'hA5, 8'h3C};
    expect_frame("good", eq, 1, 0);

    clear_log();
    start_frame(1'b1);
    send_frame(fq, 1'b1, 1'b0);
    end_frame("inv");
    expect_frame("inv", eq, 1, 0);

    clear_log();
    start_frame(1'b0);
    send_frame(fq, 1'b0, 1'b1);
    end_frame("gaps");
    expect_frame("gaps", eq, 1, 0);

    clear_log();
    start_frame(1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    end_frame("len0");
    eq = {};
    expect_frame("len0", eq, 0, 1);

    clear_log();
    start_frame(1'b0);
    send_byte(8'h41, 1'b0, 1'b0);
    end_frame("len41");
    expect_frame("len41", eq, 0, 1);

    clear_log();
    fq = '{8'h40};
    eq = {};
    for (int i = 0; i < 64; i++) begin
      fq.push_back(8'(i * 3 + 1));
      eq.push_back(8'(i * 3 + 1));
    end
    start_frame(1'b0);
    send_frame(fq, 1'b0, 1'b0);
    end_frame("len40");
    expect_frame("len40", eq, 1, 0);

    // PD drops after 11 payload bits of a LEN=3 frame: 0x11 complete, 3 bits of 0x22.
    clear_log();
    start_frame(1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    PD_flag = 1'b0;
    send_bit(1'b0, 1'b0);
    end_frame("pd_drop");
    eq = '{8'h11};
    expect_frame("pd_drop", eq, 0, 1);

    // PD falls on the very bit that completes the last byte: byte still emitted, then error.
    clear_log();
    start_frame(1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
    PD_flag = 1'b0;
    send_bit(1'b1, 1'b1);
    end_frame("pd_last");
    eq = '{8'h77};
    expect_frame("pd_last", eq, 0, 1);

    clear_log();
    start_frame(1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
    rst = 1'b1;
    tick();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data_vld", 32'(data_vld), 32'd0);
    check("mid_rst_strobes", 32'({frame_done, frame_err, disassert_BD}), 32'd0);
    rst = 1'b0; BD_flag = 1'b0; PD_flag = 1'b0; bit_vld = 1'b0;
    repeat (3) tick();
    check("mid_rst_busy_after", 32'(busy), 32'd0);
    eq = {};
    expect_frame("mid_rst", eq, 0, 0);

`ifdef RX_DEFRAME_CRC_EN
    clear_log();
    start_frame(1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'h94, 1'b0, 1'b0);
    end_frame("crc_good");
    eq = '{8'h5A};
    expect_frame("crc_good", eq, 1, 0);

    clear_log();
    start_frame(1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'h95, 1'b0, 1'b0);
    end_frame("crc_bad");
    expect_frame("crc_bad", eq, 0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
